// File: rtl/onehot_capture_pkg.sv
// Shared constants, code type and one-hot helpers for the onehot_capture slice.
package onehot_capture_pkg;

    localparam int unsigned LINES  = 8;
    localparam int unsigned CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    function automatic logic onehot_legal(input logic [LINES-1:0] din);
        return $countones(din) == 1;
    endfunction

    function automatic code_t onehot_to_code(input logic [LINES-1:0] din);
        code_t code;
        code = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            if (din[i]) code = code_t'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module code_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [CODE_W-1:0] din,
    input  logic              pop,
    output logic [CODE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is reset so the head reads 0 while the FIFO is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/onehot_capture.sv
// One-hot word checker feeding a FWFT code FIFO. Define ONEHOT_CAPTURE_ERR_CNT_EN
// to add the saturating err_count port and counter.
module onehot_capture
    import onehot_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [LINES-1:0] din,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output code_t            out_code,
    output logic             full,
    output logic             ovf,
    output logic             err_pulse
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("onehot_capture: DEPTH must be a power of 2 and at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("onehot_capture: CNT_W must be at least 1");
    end

    logic legal;
    logic illegal;
    logic pop;
    logic drop;
    logic empty;

    assign legal     = in_valid && onehot_legal(din);
    assign illegal   = in_valid && !onehot_legal(din);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = legal && full && !pop;

    code_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (legal),
        .din   (onehot_to_code(din)),
        .pop   (pop),
        .dout  (out_code),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf       <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= illegal;
            if (clr)       ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
        end
    end

`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (illegal && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_onehot_capture.sv
// Directed self-checking bench for onehot_capture (err_count checks only when
// ONEHOT_CAPTURE_ERR_CNT_EN is defined).
module tb_onehot_capture;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] din;
    logic       clr;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       full;
    logic       ovf;
    logic       err_pulse;
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int unsigned n_pass;
    int unsigned n_total;

    onehot_capture #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din       (din),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .full      (full),
        .ovf       (ovf),
        .err_pulse (err_pulse)
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
        n_total++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b want 0", err_pulse); else n_pass++;
        n_total++; if (out_code !== 3'd0) $display("FAIL reset_out_code: got %0d want 0", out_code); else n_pass++;
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
        n_total++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else n_pass++;
`endif
    endtask

    task automatic test_all_legal();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            din      = 8'h01 << i;
            tick();
            n_total++; if (out_valid !== 1'b1) $display("FAIL legal_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (out_code !== 3'(i)) $display("FAIL legal_code[%0d]: got %0d want %0d", i, out_code, i); else n_pass++;
            n_total++; if (err_pulse !== 1'b0) $display("FAIL legal_err_pulse[%0d]: got %b want 0", i, err_pulse); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL legal_drained: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din       = 8'h03;
        tick();
        n_total++; if (err_pulse !== 1'b1) $display("FAIL illegal_pulse_03: got %b want 1", err_pulse); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL illegal_valid_03: got %b want 0", out_valid); else n_pass++;
        din = 8'h00;
        tick();
        n_total++; if (err_pulse !== 1'b1) $display("FAIL illegal_pulse_00: got %b want 1", err_pulse); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL illegal_valid_00: got %b want 0", out_valid); else n_pass++;
        in_valid = 1'b0;
        din      = 8'hff;
        tick();
        n_total++; if (err_pulse !== 1'b0) $display("FAIL idle_pulse: got %b want 0", err_pulse); else n_pass++;
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
        n_total++; if (err_count !== 8'd2) $display("FAIL illegal_count: got %0d want 2", err_count); else n_pass++;
`endif
    endtask

    task automatic test_fill_overflow();
        logic [7:0] words [4];
        logic [2:0] codes [4];
        words = '{8'h20, 8'h40, 8'h80, 8'h01};
        codes = '{3'd5, 3'd6, 3'd7, 3'd0};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            din      = words[i];
            tick();
            n_total++; if (full !== (i == 3)) $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 3)); else n_pass++;
        end
        din = 8'h02;
        tick();
        n_total++; if (ovf !== 1'b1) $display("FAIL overflow_ovf: got %b want 1", ovf); else n_pass++;
        n_total++; if (full !== 1'b1) $display("FAIL overflow_full: got %b want 1", full); else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++; if (ovf !== 1'b0) $display("FAIL clr_beats_ovf: got %b want 0", ovf); else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (out_code !== codes[i]) $display("FAIL drain_code[%0d]: got %0d want %0d", i, out_code, codes[i]); else n_pass++;
            tick();
        end
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            din      = 8'h01 << i;
            tick();
        end
        n_total++; if (full !== 1'b1) $display("FAIL pp_prefull: got %b want 1", full); else n_pass++;
        out_ready = 1'b1;
        din       = 8'h10;
        tick();
        in_valid = 1'b0;
        n_total++; if (full !== 1'b1) $display("FAIL pp_full: got %b want 1", full); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL pp_ovf: got %b want 0", ovf); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_total++; if (out_code !== 3'(i)) $display("FAIL pp_code[%0d]: got %0d want %0d", i, out_code, i); else n_pass++;
            tick();
        end
        n_total++; if (out_valid !== 1'b0) $display("FAIL pp_empty: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_saturation_clear();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din       = 8'h03;
        for (int i = 0; i < 300; i++) tick();
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
        n_total++; if (err_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", err_count); else n_pass++;
`endif
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        n_total++; if (err_pulse !== 1'b1) $display("FAIL clr_pulse: got %b want 1", err_pulse); else n_pass++;
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
        n_total++; if (err_count !== 8'd0) $display("FAIL clr_count: got %0d want 0", err_count); else n_pass++;
`endif
        tick();
        n_total++; if (err_pulse !== 1'b0) $display("FAIL clr_pulse_end: got %b want 0", err_pulse); else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            din      = 8'h04;
            tick();
        end
        din = 8'h81;
        tick();
        in_valid = 1'b0;
        n_total++; if (!(full === 1'b1 && ovf === 1'b1)) $display("FAIL premid_state: got full=%b ovf=%b want 1/1", full, ovf); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL mid_full: got %b want 0", full); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL mid_ovf: got %b want 0", ovf); else n_pass++;
`ifdef ONEHOT_CAPTURE_ERR_CNT_EN
        n_total++; if (err_count !== 8'd0) $display("FAIL mid_err_count: got %0d want 0", err_count); else n_pass++;
`endif
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        din      = 8'h40;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL post_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_code !== 3'd6) $display("FAIL post_code: got %0d want 6", out_code); else n_pass++;
        tick();
        n_total++; if (out_code !== 3'd6 || out_valid !== 1'b1) $display("FAIL post_hold: got code=%0d valid=%b want 6/1", out_code, out_valid); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = 8'h00;
        clr       = 1'b0;
        out_ready = 1'b0;
        #3;
        test_reset();
        #4;
        rst_n = 1'b1;
        tick();
        test_all_legal();
        test_illegal();
        test_fill_overflow();
        test_push_pop_full();
        test_saturation_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
